// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: sequences single-port RAM access between icache fetches and dcache
// loads/stores, one transaction at a time, with a done/recvhit completion handshake.
// dcache has priority, but icache is forced in after MAX_DSTREAK back-to-back dcache grants
// while iREN is pending.
// Optional feature: define ARB_TIMEOUT_EN to add a TIMEOUT_CYC request timeout with a
// sticky timeout_err output.
module mem_arbiter_ctrl #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        irecvhit,
  input  logic        drecvhit,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iload_done,
  output logic        load_done,
  output logic        store_done
`ifdef ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3. Only ACCESS matters here.
  localparam logic [1:0] RamAccess = 2'd2;

  localparam int unsigned StreakW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65536");
  end

  typedef enum logic [2:0] {StIdle, StIreq, StDload, StDstore, StIdone, StDdone} state_t;

  state_t               state_q;
  logic [StreakW-1:0]   dstreak_q;
  logic                 req_state;
  logic                 req_live;
  logic                 ram_access;
  logic                 abort;
  logic                 tmo_hit;

  assign ram_access = (ramstate == RamAccess);

  // Identify request states and whether the granted cache still holds its strobe.
  always_comb begin
    req_state = 1'b0;
    req_live  = 1'b0;
    unique case (state_q)
      StIreq:   begin req_state = 1'b1; req_live = iREN; end
      StDload:  begin req_state = 1'b1; req_live = dREN; end
      StDstore: begin req_state = 1'b1; req_live = dWEN; end
      default:  ;
    endcase
  end

  // ACCESS wins over a same-cycle drop or timeout.
  assign abort = req_state && !ram_access && (!req_live || tmo_hit);

  // Wait releases combinationally in the ACCESS cycle of the granted cache only.
  assign iwait = !((state_q == StIreq) && ram_access);
  assign dwait = !(((state_q == StDload) || (state_q == StDstore)) && ram_access);

  // Main sequencing FSM with registered strobes, address/data, load data and done flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      dstreak_q  <= '0;
      iload      <= '0;
      dload      <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
      iload_done <= 1'b0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iREN && (dstreak_q == StreakMax)) begin
            state_q   <= StIreq;
            ramREN    <= 1'b1;
            ramaddr   <= iaddr;
            dstreak_q <= '0;
          end else if (dWEN) begin
            state_q  <= StDstore;
            ramWEN   <= 1'b1;
            ramaddr  <= daddr;
            ramstore <= dstore;
            if (iREN) dstreak_q <= dstreak_q + StreakW'(1);
          end else if (dREN) begin
            state_q <= StDload;
            ramREN  <= 1'b1;
            ramaddr <= daddr;
            if (iREN) dstreak_q <= dstreak_q + StreakW'(1);
          end else if (iREN) begin
            state_q   <= StIreq;
            ramREN    <= 1'b1;
            ramaddr   <= iaddr;
            dstreak_q <= '0;
          end
        end
        StIreq: begin
          if (ram_access) begin
            iload      <= ramload;
            iload_done <= 1'b1;
            ramREN     <= 1'b0;
            state_q    <= StIdone;
          end else if (abort) begin
            ramREN  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StDload: begin
          if (ram_access) begin
            dload     <= ramload;
            load_done <= 1'b1;
            ramREN    <= 1'b0;
            state_q   <= StDdone;
          end else if (abort) begin
            ramREN  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StDstore: begin
          if (ram_access) begin
            store_done <= 1'b1;
            ramWEN     <= 1'b0;
            state_q    <= StDdone;
          end else if (abort) begin
            ramWEN  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StIdone: begin
          if (irecvhit) begin
            iload_done <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StDdone: begin
          if (drecvhit) begin
            load_done  <= 1'b0;
            store_done <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tmo_cnt_q;

  assign tmo_hit = req_state && (tmo_cnt_q == TmoLast);

  // Count cycles spent in the current request state; error flag is sticky until reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (req_state && !ram_access && !abort) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      else                                    tmo_cnt_q <= '0;
      if (tmo_hit && !ram_access) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
